led_pattern_ctrl: RTL and testbench

Parametrised LED pattern controller driving LED_NUM LEDs from two active-low push keys. Each key is synchronised and debounced, and a press produces a single-cycle event. key[0] cycles through four display modes (off, blink, run, bounce). key[1] cycles the step speed (1x, 2x, 4x) of a free-running step timer. The block sits between the board keys/LED pins and replaces the fixed 2-LED key/LED logic.

---
 rtl/led_pattern_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: two active-low keys, each synchronised and debounced,
// select the display mode (key[0]: OFF/BLINK/RUN/BOUNCE) and the step speed
// (key[1]: 1x/2x/4x). A free-running step timer advances the pattern.
//
// Ports:
//   sys_clk    in   system clock, rising edge
//   sys_rst_n  in   asynchronous reset, active low
//   key        in   raw keys, 0 = pressed; [0] mode, [1] speed
//   led        out  LED drive, 1 = on (registered)
//   mode       out  current mode: 0 OFF, 1 BLINK, 2 RUN, 3 BOUNCE (registered)
//   step_tick  out  one-cycle pulse at the end of each step period (registered)
module led_pattern_ctrl #(
    parameter int unsigned LED_NUM = 4,
    parameter int unsigned CNT_MAX = 25000000,
    parameter int unsigned DEB_MAX = 1000000
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [1:0]         key,
    output logic [LED_NUM-1:0] led,
    output logic [1:0]         mode,
    output logic               step_tick
);

    localparam int unsigned CNT_W = $clog2(CNT_MAX);
    localparam int unsigned DEB_W = $clog2(DEB_MAX);
    localparam int unsigned POS_W = $clog2(LED_NUM);

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(LED_NUM - 1);
    localparam logic [POS_W-1:0] POS_TURN = POS_W'(LED_NUM - 2);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_MAX - 1);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_RUN    = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    // ------------------------------------------------------------------
    // Key synchronisers (2-FF per key); idle level is 1 (released)
    // ------------------------------------------------------------------
    logic [1:0] sync1_q, sync2_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: accept a new level after DEB_MAX consecutive differing cycles
    // ------------------------------------------------------------------
    logic [1:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]            stable_q, stable_d, stable_prev_q;
    logic [1:0]            press_c;
    logic                  any_press_c;

    always_comb begin
        deb_cnt_d = deb_cnt_q;
        stable_d  = stable_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                stable_d[i]  = sync2_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            deb_cnt_q     <= '0;
            stable_q      <= 2'b11;
            stable_prev_q <= 2'b11;
        end else begin
            deb_cnt_q     <= deb_cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
        end
    end

    // Press = stable level falling 1 -> 0; one cycle wide by construction
    assign press_c     = stable_prev_q & ~stable_q;
    assign any_press_c = |press_c;

    // ------------------------------------------------------------------
    // Mode FSM: state register
    // ------------------------------------------------------------------
    mode_e mode_q, mode_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q <= MODE_OFF;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Mode FSM: next state, advanced by key[0] presses
    always_comb begin
        mode_d = mode_q;
        if (press_c[0]) begin
            case (mode_q)
                MODE_OFF:    mode_d = MODE_BLINK;
                MODE_BLINK:  mode_d = MODE_RUN;
                MODE_RUN:    mode_d = MODE_BOUNCE;
                MODE_BOUNCE: mode_d = MODE_OFF;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Speed select and step timer
    // ------------------------------------------------------------------
    logic [1:0]       speed_sel_q, speed_sel_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d, step_last_c;
    logic             step_tick_q, step_tick_d;

    always_comb begin
        speed_sel_d = speed_sel_q;
        if (press_c[1]) begin
            speed_sel_d = (speed_sel_q == 2'd2) ? 2'd0 : speed_sel_q + 2'd1;
        end
    end

    // Terminal count for the current speed (period = CNT_MAX >> speed_sel)
    always_comb begin
        case (speed_sel_q)
            2'd1:    step_last_c = CNT_W'((CNT_MAX >> 1) - 1);
            2'd2:    step_last_c = CNT_W'((CNT_MAX >> 2) - 1);
            default: step_last_c = CNT_W'(CNT_MAX - 1);
        endcase
    end

    // A press restarts the period and swallows a tick due in the same cycle
    always_comb begin
        step_tick_d = 1'b0;
        step_cnt_d  = step_cnt_q + CNT_W'(1);
        if (any_press_c) begin
            step_cnt_d = '0;
        end else if (step_cnt_q == step_last_c) begin
            step_cnt_d  = '0;
            step_tick_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pattern state: advances on step_tick, reinitialised by any press
    // ------------------------------------------------------------------
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;     // 0 = up, 1 = down
    logic             phase_q, phase_d;

    always_comb begin
        pos_d   = pos_q;
        dir_d   = dir_q;
        phase_d = phase_q;
        if (any_press_c) begin
            pos_d   = '0;
            dir_d   = 1'b0;
            phase_d = 1'b0;
        end else if (step_tick_q) begin
            case (mode_q)
                MODE_BLINK: phase_d = ~phase_q;
                MODE_RUN:   pos_d   = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
                MODE_BOUNCE: begin
                    // End LEDs are shown once per sweep: turn immediately
                    if (!dir_q) begin
                        if (pos_q == POS_LAST) begin
                            dir_d = 1'b1;
                            pos_d = POS_TURN;
                        end else begin
                            pos_d = pos_q + POS_W'(1);
                        end
                    end else begin
                        if (pos_q == '0) begin
                            dir_d = 1'b0;
                            pos_d = POS_W'(1);
                        end else begin
                            pos_d = pos_q - POS_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Mode FSM: output decode (registered into led_q)
    // ------------------------------------------------------------------
    logic [LED_NUM-1:0] led_q, led_d;

    always_comb begin
        led_d = '0;
        case (mode_q)
            MODE_BLINK:  led_d = phase_q ? '1 : '0;
            MODE_RUN:    led_d = LED_NUM'(1) << pos_q;
            MODE_BOUNCE: led_d = LED_NUM'(1) << pos_q;
            default:     led_d = '0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            speed_sel_q <= 2'd0;
            step_cnt_q  <= '0;
            step_tick_q <= 1'b0;
            pos_q       <= '0;
            dir_q       <= 1'b0;
            phase_q     <= 1'b0;
            led_q       <= '0;
        end else begin
            speed_sel_q <= speed_sel_d;
            step_cnt_q  <= step_cnt_d;
            step_tick_q <= step_tick_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            phase_q     <= phase_d;
            led_q       <= led_d;
        end
    end

    assign led       = led_q;
    assign mode      = mode_q;
    assign step_tick = step_tick_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Testbench for led_pattern_ctrl: table of key actions with expected modes,
// hand-timed sequences for latency, speed, mid-period and simultaneous presses,
// and random key activity compared every cycle against a reference model.
module tb_led_pattern_ctrl;

    localparam int LED_NUM = 4;
    localparam int CNT_MAX = 16;
    localparam int DEB_MAX = 4;
    localparam int K_MOD   = 2 * LED_NUM * (LED_NUM - 1);

    logic               sys_clk = 1'b0;
    logic               sys_rst_n;
    logic [1:0]         key;
    logic [LED_NUM-1:0] led;
    logic [1:0]         mode;
    logic               step_tick;

    int errors = 0;
    int checks = 0;

    led_pattern_ctrl #(
        .LED_NUM(LED_NUM),
        .CNT_MAX(CNT_MAX),
        .DEB_MAX(DEB_MAX)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .key      (key),
        .led      (led),
        .mode     (mode),
        .step_tick(step_tick)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. The pattern is a step count k since the last press;
    // the displayed LED is a pure function of (mode, k).
    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0]         s1, s2, stable, prev;
        int                 run0, run1;
        int                 mode, speed, cnt, k;
        logic               tick;
        logic [LED_NUM-1:0] led;
    } model_t;

    model_t m;

    function automatic logic [LED_NUM-1:0] pattern(input int md, input int k);
        logic [LED_NUM-1:0] one;
        int j;
        one    = '0;
        one[0] = 1'b1;
        j = k % (2 * (LED_NUM - 1));
        if (j >= LED_NUM) j = 2 * (LED_NUM - 1) - j;
        case (md)
            1:       return (k % 2 == 1) ? '1 : '0;
            2:       return one << (k % LED_NUM);
            3:       return one << j;
            default: return '0;
        endcase
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.s1 = 2'b11; r.s2 = 2'b11; r.stable = 2'b11; r.prev = 2'b11;
        r.run0 = 0; r.run1 = 0;
        r.mode = 0; r.speed = 0; r.cnt = 0; r.k = 0;
        r.tick = 1'b0; r.led = '0;
        return r;
    endfunction

    function automatic model_t model_next(input model_t c, input logic [1:0] k_in);
        model_t     n;
        logic [1:0] press;
        int         period;
        int         r[2];
        n      = c;
        press  = c.prev & ~c.stable;
        period = CNT_MAX >> c.speed;
        n.tick = (press == 2'b00) && (c.cnt == period - 1);
        n.cnt  = (press != 2'b00) ? 0 : (c.cnt + 1) % period;
        n.led  = pattern(c.mode, c.k);
        if (press != 2'b00)             n.k = 0;
        else if (c.tick && c.mode != 0) n.k = (c.k + 1) % K_MOD;
        if (press[0]) n.mode  = (c.mode + 1) % 4;
        if (press[1]) n.speed = (c.speed + 1) % 3;
        // A new level is accepted after DEB_MAX consecutive differing cycles
        r[0] = c.run0;
        r[1] = c.run1;
        for (int i = 0; i < 2; i++) begin
            if (c.s2[i] == c.stable[i]) begin
                r[i] = 0;
            end else if (r[i] + 1 >= DEB_MAX) begin
                n.stable[i] = c.s2[i];
                r[i] = 0;
            end else begin
                r[i] = r[i] + 1;
            end
        end
        n.run0 = r[0];
        n.run1 = r[1];
        n.s1   = k_in;
        n.s2   = c.s1;
        n.prev = c.stable;
        return n;
    endfunction

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) m <= model_reset();
        else            m <= model_next(m, key);
    end

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            check("cyc_led",  32'(led),       32'(m.led));
            check("cyc_mode", 32'(mode),      32'(m.mode));
            check("cyc_tick", 32'(step_tick), 32'(m.tick));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic press(input logic [1:0] k);
        key = k;
        repeat (12) step();
        key = 2'b11;
        repeat (10) step();
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 64 && !seen; n++) begin
            step();
            if (step_tick) seen = 1'b1;
        end
        check("wait_tick", 32'(seen), 32'd1);
    endtask

    task automatic measure_gap(output int gap);
        bit seen;
        wait_tick();
        gap  = 0;
        seen = 1'b0;
        for (int n = 1; n <= 64 && !seen; n++) begin
            step();
            if (step_tick) begin
                gap  = n;
                seen = 1'b1;
            end
        end
    endtask

    task automatic idle_check(input string name);
        logic [LED_NUM-1:0] led_or;
        led_or = '0;
        key = 2'b11;
        for (int n = 0; n < 200; n++) begin
            step();
            led_or |= led;
        end
        check(name, 32'(led_or), 32'd0);
    endtask

    typedef struct {
        logic [1:0] key;
        int         cycles;
        int         exp_mode;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int gap;
        int lat;
        int idx;

        vecs[0]  = '{2'b11,  40, 1};
        vecs[1]  = '{2'b10,   3, 1};
        vecs[2]  = '{2'b11,  10, 1};
        vecs[3]  = '{2'b10,  12, 2};
        vecs[4]  = '{2'b11,  80, 2};
        vecs[5]  = '{2'b10,  12, 3};
        vecs[6]  = '{2'b11, 110, 3};
        vecs[7]  = '{2'b01,  12, 3};
        vecs[8]  = '{2'b11,  20, 3};
        vecs[9]  = '{2'b10,  12, 0};
        vecs[10] = '{2'b11,  10, 0};
        vecs[11] = '{2'b00,  12, 1};
        vecs[12] = '{2'b11,  10, 1};
        vecs[13] = '{2'b01,  12, 1};
        vecs[14] = '{2'b11,  10, 1};

        sys_rst_n = 1'b1;
        key       = 2'b11;
        #1 sys_rst_n = 1'b0;
        #2;
        check("rst_led",  32'(led),       32'd0);
        check("rst_mode", 32'(mode),      32'd0);
        check("rst_tick", 32'(step_tick), 32'd0);
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;

        // Idle after reset: LEDs dark, tick every CNT_MAX cycles
        idle_check("idle_led");
        measure_gap(gap);
        check("idle_gap", 32'(gap), 32'd16);

        // Press latency: mode updates DEB_MAX+3 edges after first low sample
        key = 2'b10;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (lat == 0 && mode == 2'd1) lat = n;
        end
        check("press_latency", 32'(lat), 32'd7);
        key = 2'b11;
        repeat (20) step();
        check("hold_release_mode", 32'(mode), 32'd1);

        // Table of key actions with expected mode afterwards
        for (int v = 0; v < 15; v++) begin
            key = vecs[v].key;
            repeat (vecs[v].cycles) step();
            check($sformatf("vec%0d_mode", v), 32'(mode), 32'(vecs[v].exp_mode));
        end

        // Asynchronous reset mid-run, observed before any clock edge
        step();
        #2 sys_rst_n = 1'b0;
        #1;
        check("async_rst_led",  32'(led),       32'd0);
        check("async_rst_mode", 32'(mode),      32'd0);
        check("async_rst_tick", 32'(step_tick), 32'd0);
        step();
        step();
        sys_rst_n = 1'b1;
        idle_check("idle_led_after_rst");

        // Speed cycling: period 8, 4, back to 16
        press(2'b01);
        measure_gap(gap);
        check("speed1_gap", 32'(gap), 32'd8);
        press(2'b01);
        measure_gap(gap);
        check("speed2_gap", 32'(gap), 32'd4);
        press(2'b01);
        measure_gap(gap);
        check("speed0_gap", 32'(gap), 32'd16);

        // Speed press while the counter is at 12 (RUN, speed 0)
        press(2'b10);
        press(2'b10);
        repeat (40) step();
        wait_tick();
        repeat (6) step();
        key = 2'b01;
        idx = 0;
        for (int n = 1; n <= 24; n++) begin
            step();
            if (n == 8) check("press_mid_pos0", 32'(led), 32'd1);
            if (idx == 0 && step_tick) idx = n;
        end
        check("press_mid_gap", 32'(idx - 7), 32'd8);
        key = 2'b11;
        repeat (12) step();

        // Simultaneous press from BOUNCE at speed 2, on a cycle with a tick due
        press(2'b10);
        press(2'b01);
        repeat (20) step();
        wait_tick();
        step();
        key = 2'b00;
        idx = 0;
        for (int n = 1; n <= 30; n++) begin
            step();
            if (n == 7) begin
                check("simul_mode", 32'(mode),      32'd0);
                check("simul_tick", 32'(step_tick), 32'd0);
            end
            if (n == 8) check("simul_led", 32'(led), 32'd0);
            if (n > 7 && idx == 0 && step_tick) idx = n;
        end
        check("simul_gap", 32'(idx - 7), 32'd16);
        key = 2'b11;
        repeat (12) step();

        // Random key activity against the model
        for (int s = 0; s < 60; s++) begin
            key = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 25)) step();
        end
        key = 2'b11;
        repeat (30) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
